// File: rtl/duty_ramp_ctrl_if.sv
// Duty ramp request/status bundle.
//   target : requested final duty (R+1 bits), sampled on an accepted load
//   load   : request strobe
//   ciclo  : current registered duty (R+1 bits), drives the PWM duty input
//   busy   : high while ramping
//   done   : one-cycle pulse when the ramp reaches its target
// master = requester side, slave = duty_ramp_ctrl side.
interface duty_ramp_ctrl_if #(
  parameter int unsigned R = 8
);
  logic [R:0] target;
  logic       load;
  logic [R:0] ciclo;
  logic       busy;
  logic       done;

  modport master (
    output target,
    output load,
    input  ciclo,
    input  busy,
    input  done
  );

  modport slave (
    input  target,
    input  load,
    output ciclo,
    output busy,
    output done
  );
endinterface

// File: rtl/duty_ramp_ctrl.sv
// Duty-cycle ramp controller.
// Moves the PWM duty word ciclo toward a requested target in steps of STEP_SIZE,
// one step every STEP_INTERVAL clocks, then pulses done.
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous, active-high
//   bus   : duty_ramp_ctrl_if slave (target/load in, ciclo/busy/done out)
module duty_ramp_ctrl #(
  parameter int unsigned R             = 8,
  parameter int unsigned TIMER_BITS    = 15,
  parameter int unsigned STEP_INTERVAL = 10000,
  parameter int unsigned STEP_SIZE     = 1
) (
  input logic              clk,
  input logic              reset,
  duty_ramp_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StRamp, StDone} state_e;

  localparam logic [R:0]            FullDuty = {1'b1, {R{1'b0}}};
  localparam logic [R+1:0]          StepW    = (R+2)'(STEP_SIZE);
  localparam logic [TIMER_BITS-1:0] LastCnt  = TIMER_BITS'(STEP_INTERVAL - 1);

  state_e                state_q;
  logic [R:0]            ciclo_q;
  logic [R:0]            tgt_q;
  logic [TIMER_BITS-1:0] cnt_q;
  logic                  busy_q;
  logic                  done_q;

  logic [R:0]   tgt_load;
  logic [R+1:0] tgt_ext;
  logic [R+1:0] cur_ext;
  logic [R+1:0] mag;
  logic         up;
  logic         close;
  logic [R:0]   step_val;

  // Anything above 100% duty is clamped to exactly 2^R.
  assign tgt_load = (bus.target > FullDuty) ? FullDuty : bus.target;

  // Step math one bit wider than ciclo so ciclo +/- STEP_SIZE never wraps;
  // a step is only taken when the distance exceeds STEP_SIZE, so the result
  // stays within [0, 2^R].
  always_comb begin
    tgt_ext  = {1'b0, tgt_q};
    cur_ext  = {1'b0, ciclo_q};
    up       = cur_ext < tgt_ext;
    mag      = up ? (tgt_ext - cur_ext) : (cur_ext - tgt_ext);
    close    = mag <= StepW;
    step_val = tgt_q;
    if (!close) begin
      step_val = up ? (R+1)'(cur_ext + StepW) : (R+1)'(cur_ext - StepW);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      ciclo_q <= '0;
      tgt_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else if (bus.load) begin
      // Load wins from every state, including a retarget mid-ramp and DONE.
      state_q <= StRamp;
      tgt_q   <= tgt_load;
      cnt_q   <= '0;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          cnt_q  <= '0;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
        StRamp: begin
          if (cnt_q == LastCnt) begin
            cnt_q   <= '0;
            ciclo_q <= step_val;
            if (close) begin
              state_q <= StDone;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + TIMER_BITS'(1);
          end
        end
        StDone: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ciclo = ciclo_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;

endmodule

// File: tb/tb_duty_ramp_ctrl.sv
module tb_duty_ramp_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;

  duty_ramp_ctrl_if #(.R(8)) bus ();

  duty_ramp_ctrl #(
    .R            (8),
    .TIMER_BITS   (15),
    .STEP_INTERVAL(4),
    .STEP_SIZE    (16)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       ld;
    logic [8:0] tgt;
    logic [8:0] ciclo;
    logic       busy;
    logic       done;
  } vec_t;

  vec_t vecs[$];
  int   tests = 0;
  int   failed = 0;
  int   dones;

  task automatic chk(input string name, input int got, input int exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic ld, input int tgt, input int c, input logic b, input logic d);
    vec_t v;
    v.ld = ld; v.tgt = 9'(tgt); v.ciclo = 9'(c); v.busy = b; v.done = d;
    vecs.push_back(v);
  endtask

  // Three non-step cycles at prev, then the step edge landing on nxt.
  task automatic add_step(input int prev, input int nxt, input logic last);
    for (int i = 0; i < 3; i++) add(1'b0, 0, prev, 1'b1, 1'b0);
    add(1'b0, 0, nxt, !last, last);
  endtask

  task automatic check_out(input string tag, input int c, input logic b, input logic d);
    chk({tag, " ciclo"}, int'(bus.ciclo), c);
    chk({tag, " busy"}, int'(bus.busy), int'(b));
    chk({tag, " done"}, int'(bus.done), int'(d));
  endtask

  initial begin
    bus.load   = 1'b0;
    bus.target = '0;

    // Up-ramp 0 -> 64
    add(1'b1, 64, 0, 1'b1, 1'b0);
    add_step(0, 16, 1'b0);
    add_step(16, 32, 1'b0);
    add_step(32, 48, 1'b0);
    add_step(48, 64, 1'b1);
    add(1'b0, 0, 64, 1'b0, 1'b0);
    add(1'b0, 0, 64, 1'b0, 1'b0);
    // Down-ramp 64 -> 10 with a partial last step
    add(1'b1, 10, 64, 1'b1, 1'b0);
    add_step(64, 48, 1'b0);
    add_step(48, 32, 1'b0);
    add_step(32, 16, 1'b0);
    add_step(16, 10, 1'b1);
    add(1'b0, 0, 10, 1'b0, 1'b0);
    // 400 clamps to 256: 10, 26, ..., 250, 256
    add(1'b1, 400, 10, 1'b1, 1'b0);
    for (int k = 1; k <= 15; k++) add_step(10 + 16 * (k - 1), 10 + 16 * k, 1'b0);
    add_step(250, 256, 1'b1);
    add(1'b0, 0, 256, 1'b0, 1'b0);
    // 256 back to 0 in exact steps of 16, no wrap
    add(1'b1, 0, 256, 1'b1, 1'b0);
    for (int k = 1; k <= 15; k++) add_step(256 - 16 * (k - 1), 256 - 16 * k, 1'b0);
    add_step(16, 0, 1'b1);
    add(1'b0, 0, 0, 1'b0, 1'b0);

    // Reset state
    tick();
    tick();
    check_out("reset", 0, 1'b0, 1'b0);
    reset = 1'b0;
    tick();
    check_out("idle_noload", 0, 1'b0, 1'b0);

    foreach (vecs[i]) begin
      bus.load   = vecs[i].ld;
      bus.target = vecs[i].tgt;
      tick();
      check_out($sformatf("vec%0d", i), int'(vecs[i].ciclo), vecs[i].busy, vecs[i].done);
    end
    bus.load = 1'b0;

    // Retarget at ciclo=48 during a ramp to 200
    dones = 0;
    bus.load = 1'b1; bus.target = 9'd200;
    tick();
    bus.load = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (bus.done) dones++;
    end
    chk("rt pre ciclo", int'(bus.ciclo), 48);
    bus.load = 1'b1; bus.target = 9'd0;
    tick();
    bus.load = 1'b0;
    if (bus.done) dones++;
    chk("rt load ciclo", int'(bus.ciclo), 48);
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (bus.done) dones++;
      if (i == 3)  chk("rt hold ciclo", int'(bus.ciclo), 48);
      if (i == 4)  chk("rt step1 ciclo", int'(bus.ciclo), 32);
      if (i == 8)  chk("rt step2 ciclo", int'(bus.ciclo), 16);
      if (i == 12) check_out("rt end", 0, 1'b0, 1'b1);
    end
    tick();
    if (bus.done) dones++;
    chk("rt busy after", int'(bus.busy), 0);
    chk("rt done count", dones, 1);

    // Async reset mid-ramp at ciclo=96
    bus.load = 1'b1; bus.target = 9'd200;
    tick();
    bus.load = 1'b0;
    repeat (24) tick();
    chk("ar pre ciclo", int'(bus.ciclo), 96);
    chk("ar pre busy", int'(bus.busy), 1);
    reset = 1'b1;
    #1;
    check_out("ar async", 0, 1'b0, 1'b0);
    // A load during reset must be ignored.
    bus.load = 1'b1; bus.target = 9'd64;
    tick();
    check_out("ar held", 0, 1'b0, 1'b0);
    bus.load = 1'b0;
    reset = 1'b0;
    tick();
    check_out("ar release", 0, 1'b0, 1'b0);
    bus.load = 1'b1; bus.target = 9'd64;
    tick();
    bus.load = 1'b0;
    repeat (3) tick();
    chk("ar restart hold", int'(bus.ciclo), 0);
    tick();
    chk("ar restart step", int'(bus.ciclo), 16);
    repeat (12) tick();
    check_out("ar restart end", 64, 1'b0, 1'b1);
    tick();

    // Equal target, then load in the DONE cycle
    bus.load = 1'b1; bus.target = 9'd64;
    tick();
    bus.load = 1'b0;
    check_out("eq load", 64, 1'b1, 1'b0);
    repeat (3) tick();
    tick();
    check_out("eq done", 64, 1'b0, 1'b1);
    bus.load = 1'b1; bus.target = 9'd32;
    tick();
    bus.load = 1'b0;
    check_out("dl reload", 64, 1'b1, 1'b0);
    repeat (4) tick();
    check_out("dl step1", 48, 1'b1, 1'b0);
    repeat (4) tick();
    check_out("dl end", 32, 1'b0, 1'b1);
    tick();
    check_out("dl idle", 32, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
